// File: rtl/rv_decode_pkg.sv
// ----------------------------------------------------------------------------
// rv_decode_pkg
//   Shared definitions for the decode stage:
//     - RV64 major-opcode constants
//     - op_class_e: instruction format class (R, I, U, J, B, S, SYS, ILL)
//     - fixed bit offsets of instruction fields (independent of lane count)
//     - classify(): opcode -> class
// ----------------------------------------------------------------------------
package rv_decode_pkg;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32  = 7'b0011011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_FENCE    = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam int INSTR_W = 32;
    localparam int OPC_LSB = 0;
    localparam int RD_LSB  = 7;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int F7_BIT  = 30;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_U,
        CLS_J,
        CLS_B,
        CLS_S,
        CLS_SYS,
        CLS_ILL
    } op_class_e;

    function automatic op_class_e classify(input logic [6:0] opc);
        op_class_e cls;
        case (opc)
            OPC_OP, OPC_OP32:                            cls = CLS_R;
            OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_OPIMM32:  cls = CLS_I;
            OPC_LUI, OPC_AUIPC:                          cls = CLS_U;
            OPC_JAL:                                     cls = CLS_J;
            OPC_BRANCH:                                  cls = CLS_B;
            OPC_STORE:                                   cls = CLS_S;
            OPC_FENCE, OPC_SYSTEM:                       cls = CLS_SYS;
            default:                                     cls = CLS_ILL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/decode_lane.sv
// ----------------------------------------------------------------------------
// decode_lane
//   Purely combinational single-instruction decoder.
//   Ports:
//     instr    in   32-bit instruction word
//     lane_v   in   lane carries a real instruction
//     opcode, func3, func7 (instr[30]), rs1, rs2, rd   out  raw fields
//     imme     out  sign-extended immediate (0 for R/FENCE/SYSTEM/illegal)
//     prs1_v, prs2_v, prd_v   out  operand-valid flags
//     illegal  out  valid lane whose opcode matches no class
//   An invalid lane drives every output to zero.
// ----------------------------------------------------------------------------
module decode_lane
    import rv_decode_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [31:0]           instr,
    input  logic                  lane_v,
    output logic [6:0]            opcode,
    output logic [2:0]            func3,
    output logic                  func7,
    output logic [4:0]            rs1,
    output logic [4:0]            rs2,
    output logic [4:0]            rd,
    output logic [DATA_WIDTH-1:0] imme,
    output logic                  prs1_v,
    output logic                  prs2_v,
    output logic                  prd_v,
    output logic                  illegal
);

    // Every format's immediate fits in 32 bits once its own sign bit is
    // replicated, so a single widening step covers all of them.
    function automatic logic signed [DATA_WIDTH-1:0] sext_imm(input logic signed [31:0] v);
        return DATA_WIDTH'(v);
    endfunction

    op_class_e          cls;
    logic signed [31:0] imm32;
    logic               is_r, is_i, is_u, is_j, is_b, is_s;

    always_comb begin
        cls     = classify(instr[OPC_LSB +: 7]);
        imm32   = '0;
        opcode  = '0;
        func3   = '0;
        func7   = 1'b0;
        rs1     = '0;
        rs2     = '0;
        rd      = '0;
        imme    = '0;
        prs1_v  = 1'b0;
        prs2_v  = 1'b0;
        prd_v   = 1'b0;
        illegal = 1'b0;
        is_r    = (cls == CLS_R);
        is_i    = (cls == CLS_I);
        is_u    = (cls == CLS_U);
        is_j    = (cls == CLS_J);
        is_b    = (cls == CLS_B);
        is_s    = (cls == CLS_S);

        case (cls)
            CLS_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            CLS_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            CLS_B:   imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            CLS_U:   imm32 = {instr[31:12], 12'b0};
            CLS_J:   imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase

        if (lane_v) begin
            opcode  = instr[OPC_LSB +: 7];
            func3   = instr[F3_LSB +: 3];
            func7   = instr[F7_BIT];
            rs1     = instr[RS1_LSB +: 5];
            rs2     = instr[RS2_LSB +: 5];
            rd      = instr[RD_LSB +: 5];
            imme    = sext_imm(imm32);
            prs1_v  = is_r | is_i | is_s | is_b;
            prs2_v  = is_r | is_s | is_b;
            prd_v   = (is_r | is_i | is_u | is_j) & (instr[RD_LSB +: 5] != 5'd0);
            illegal = (cls == CLS_ILL);
        end
    end

endmodule

// File: rtl/decode_stage.sv
// ----------------------------------------------------------------------------
// decode_stage
//   Registered, handshaked group decoder between fetch queue and rename.
//   Decodes DECODE_NUM lanes per cycle, squashes lanes younger than the first
//   illegal lane, and holds results in a main register backed by a one-group
//   skid register so in_ready never depends combinationally on out_ready.
//
//   Ports:
//     clk, rst (async, active-high), flush (drops main and skid contents)
//     in_valid/in_ready, in_instr (lane i at [32i+31:32i]), in_lane_v,
//     in_pc (lane 0 PC; lane i = in_pc + 4i)
//     out_valid/out_ready, out_lane_v, out_pc, out_opcode, out_func3,
//     out_func7, out_rs1, out_rs2, out_rd, out_imme, out_prs1_v, out_prs2_v,
//     out_prd_v, out_illegal  (all lane-packed, lane 0 in the LSBs)
//
//   Optional build macro DECODE_STAGE_PERF_EN adds 64-bit wrapping counters
//   perf_group_cnt, perf_instr_cnt, perf_stall_cnt (not cleared by flush).
// ----------------------------------------------------------------------------
module decode_stage
    import rv_decode_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DECODE_NUM = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DECODE_NUM*32-1:0]         in_instr,
    input  logic [DECODE_NUM-1:0]            in_lane_v,
    input  logic [DATA_WIDTH-1:0]            in_pc,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DECODE_NUM-1:0]            out_lane_v,
    output logic [DECODE_NUM*DATA_WIDTH-1:0] out_pc,
    output logic [7*DECODE_NUM-1:0]          out_opcode,
    output logic [3*DECODE_NUM-1:0]          out_func3,
    output logic [DECODE_NUM-1:0]            out_func7,
    output logic [5*DECODE_NUM-1:0]          out_rs1,
    output logic [5*DECODE_NUM-1:0]          out_rs2,
    output logic [5*DECODE_NUM-1:0]          out_rd,
    output logic [DECODE_NUM*DATA_WIDTH-1:0] out_imme,
    output logic [DECODE_NUM-1:0]            out_prs1_v,
    output logic [DECODE_NUM-1:0]            out_prs2_v,
    output logic [DECODE_NUM-1:0]            out_prd_v,
    output logic [DECODE_NUM-1:0]            out_illegal
`ifdef DECODE_STAGE_PERF_EN
   ,output logic [63:0]                      perf_group_cnt,
    output logic [63:0]                      perf_instr_cnt,
    output logic [63:0]                      perf_stall_cnt
`endif
);

    localparam int N     = DECODE_NUM;
    localparam int W     = DATA_WIDTH;
    localparam int GRP_W = N * (2 * W + 31);

    logic [6:0] l_opc  [N];
    logic [2:0] l_f3   [N];
    logic       l_f7   [N];
    logic [4:0] l_rs1  [N];
    logic [4:0] l_rs2  [N];
    logic [4:0] l_rd   [N];
    logic [W-1:0] l_imm [N];
    logic       l_prs1 [N];
    logic       l_prs2 [N];
    logic       l_prd  [N];
    logic       l_ill  [N];

    logic [N-1:0]   lane_v_p0, f7_p0, prs1_p0, prs2_p0, prd_p0, ill_p0;
    logic [N*W-1:0] pc_p0, imm_p0;
    logic [7*N-1:0] opc_p0;
    logic [3*N-1:0] f3_p0;
    logic [5*N-1:0] rs1_p0, rs2_p0, rd_p0;
    logic [GRP_W-1:0] grp_p0;

    logic [GRP_W-1:0] main_p1, skid_p1;
    logic             vld_main_p1, vld_skid_p1;
    logic             accept, drain;

    // ---- stage p0: per-lane decode --------------------------------------
    for (genvar i = 0; i < N; i++) begin : g_lane
        decode_lane #(.DATA_WIDTH(W)) u_lane (
            .instr   (in_instr[32*i +: 32]),
            .lane_v  (in_lane_v[i]),
            .opcode  (l_opc[i]),
            .func3   (l_f3[i]),
            .func7   (l_f7[i]),
            .rs1     (l_rs1[i]),
            .rs2     (l_rs2[i]),
            .rd      (l_rd[i]),
            .imme    (l_imm[i]),
            .prs1_v  (l_prs1[i]),
            .prs2_v  (l_prs2[i]),
            .prd_v   (l_prd[i]),
            .illegal (l_ill[i])
        );
    end

    // Squash chain: once an illegal lane is seen, every younger lane is
    // dropped entirely (valid and all fields zero). The illegal lane itself
    // is kept so rename can raise the exception at the right PC.
    always_comb begin
        logic ill_seen;
        ill_seen  = 1'b0;
        lane_v_p0 = '0;
        pc_p0     = '0;
        opc_p0    = '0;
        f3_p0     = '0;
        f7_p0     = '0;
        rs1_p0    = '0;
        rs2_p0    = '0;
        rd_p0     = '0;
        imm_p0    = '0;
        prs1_p0   = '0;
        prs2_p0   = '0;
        prd_p0    = '0;
        ill_p0    = '0;
        for (int i = 0; i < N; i++) begin
            if (in_lane_v[i] && !ill_seen) begin
                lane_v_p0[i]       = 1'b1;
                pc_p0[W*i +: W]    = in_pc + W'(4 * i);
                opc_p0[7*i +: 7]   = l_opc[i];
                f3_p0[3*i +: 3]    = l_f3[i];
                f7_p0[i]           = l_f7[i];
                rs1_p0[5*i +: 5]   = l_rs1[i];
                rs2_p0[5*i +: 5]   = l_rs2[i];
                rd_p0[5*i +: 5]    = l_rd[i];
                imm_p0[W*i +: W]   = l_imm[i];
                prs1_p0[i]         = l_prs1[i];
                prs2_p0[i]         = l_prs2[i];
                prd_p0[i]          = l_prd[i];
                ill_p0[i]          = l_ill[i];
            end
            if (l_ill[i]) begin
                ill_seen = 1'b1;
            end
        end
    end

    assign grp_p0 = {lane_v_p0, pc_p0, opc_p0, f3_p0, f7_p0, rs1_p0, rs2_p0,
                     rd_p0, imm_p0, prs1_p0, prs2_p0, prd_p0, ill_p0};

    // ---- stage p1: main + skid registers ---------------------------------
    assign in_ready  = !vld_skid_p1;
    assign out_valid = vld_main_p1;
    assign accept    = in_valid & in_ready;
    assign drain     = vld_main_p1 & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_main_p1 <= 1'b0;
            vld_skid_p1 <= 1'b0;
            main_p1     <= '0;
            skid_p1     <= '0;
        end else if (flush) begin
            vld_main_p1 <= 1'b0;
            vld_skid_p1 <= 1'b0;
        end else if (!vld_main_p1 || drain) begin
            // Main is free this edge: the older skid group has priority.
            // in_ready is low whenever skid is full, so no accept can race it.
            if (vld_skid_p1) begin
                main_p1     <= skid_p1;
                vld_main_p1 <= 1'b1;
                vld_skid_p1 <= 1'b0;
            end else if (accept) begin
                main_p1     <= grp_p0;
                vld_main_p1 <= 1'b1;
            end else begin
                vld_main_p1 <= 1'b0;
            end
        end else if (accept) begin
            skid_p1     <= grp_p0;
            vld_skid_p1 <= 1'b1;
        end
    end

    assign {out_lane_v, out_pc, out_opcode, out_func3, out_func7, out_rs1,
            out_rs2, out_rd, out_imme, out_prs1_v, out_prs2_v, out_prd_v,
            out_illegal} = main_p1;

`ifdef DECODE_STAGE_PERF_EN
    function automatic logic [63:0] popcnt(input logic [N-1:0] v);
        logic [63:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + 64'(v[i]);
        end
        return c;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_group_cnt <= '0;
            perf_instr_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (drain) begin
                perf_group_cnt <= perf_group_cnt + 64'd1;
                perf_instr_cnt <= perf_instr_cnt + popcnt(out_lane_v);
            end
            if (vld_main_p1 && !out_ready) begin
                perf_stall_cnt <= perf_stall_cnt + 64'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// ----------------------------------------------------------------------------
// tb_decode_stage
//   Directed self-checking bench for decode_stage (DECODE_NUM=4, 64-bit).
//   Build with +define+DECODE_STAGE_PERF_EN to include the counter checks.
// ----------------------------------------------------------------------------
module tb_decode_stage;

    localparam int N = 4;
    localparam int W = 64;

    logic           clk;
    logic           rst;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [N*32-1:0] in_instr;
    logic [N-1:0]   in_lane_v;
    logic [W-1:0]   in_pc;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   out_lane_v;
    logic [N*W-1:0] out_pc;
    logic [7*N-1:0] out_opcode;
    logic [3*N-1:0] out_func3;
    logic [N-1:0]   out_func7;
    logic [5*N-1:0] out_rs1;
    logic [5*N-1:0] out_rs2;
    logic [5*N-1:0] out_rd;
    logic [N*W-1:0] out_imme;
    logic [N-1:0]   out_prs1_v;
    logic [N-1:0]   out_prs2_v;
    logic [N-1:0]   out_prd_v;
    logic [N-1:0]   out_illegal;
`ifdef DECODE_STAGE_PERF_EN
    logic [63:0]    perf_group_cnt;
    logic [63:0]    perf_instr_cnt;
    logic [63:0]    perf_stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] deliv[$];

    decode_stage #(.DATA_WIDTH(W), .DECODE_NUM(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_lane_v   (in_lane_v),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_lane_v  (out_lane_v),
        .out_pc      (out_pc),
        .out_opcode  (out_opcode),
        .out_func3   (out_func3),
        .out_func7   (out_func7),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_rd      (out_rd),
        .out_imme    (out_imme),
        .out_prs1_v  (out_prs1_v),
        .out_prs2_v  (out_prs2_v),
        .out_prd_v   (out_prd_v),
        .out_illegal (out_illegal)
`ifdef DECODE_STAGE_PERF_EN
       ,.perf_group_cnt (perf_group_cnt),
        .perf_instr_cnt (perf_instr_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record lane-0 PC of every delivered group; the handshake completes on
    // the following rising edge and inputs are stable at the falling edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            deliv.push_back(out_pc[63:0]);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Present a group starting just after a rising edge and hold it until
    // accepted; returns 1 time unit after the accepting edge.
    task automatic send_grp(input logic [63:0] pc, input logic [127:0] instrs, input logic [3:0] lv);
        logic ok;
        ok        = 1'b0;
        in_pc     = pc;
        in_instr  = instrs;
        in_lane_v = lv;
        in_valid  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("send_accept", 64'(ok), 64'd1);
    endtask

    function automatic logic [63:0] q_at(input int k);
        return (deliv.size() > k) ? deliv[k] : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_lane_v = '0;
        in_pc     = '0;
        out_ready = 1'b1;

        // Reset state, during and after reset.
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_lane_v", 64'(out_lane_v), 64'd0);
        chk("rst_imme0", out_imme[63:0], 64'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Mixed group: addi x1,x0,5 / sw x2,8(x1) / add x0,x1,x2 / nop.
        send_grp(64'h1000, {32'h00000013, 32'h00208033, 32'h0020A423, 32'h00500093}, 4'b1111);
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_lane_v", 64'(out_lane_v), 64'hF);
        chk("t1_imme0", out_imme[63:0], 64'd5);
        chk("t1_imme1", out_imme[127:64], 64'd8);
        chk("t1_prs1_v", 64'(out_prs1_v), 64'b1111);
        chk("t1_prs2_v", 64'(out_prs2_v), 64'b0110);
        chk("t1_prd_v", 64'(out_prd_v), 64'b0001);
        chk("t1_illegal", 64'(out_illegal), 64'd0);
        chk("t1_rd0", 64'(out_rd[4:0]), 64'd1);
        chk("t1_rs2_1", 64'(out_rs2[9:5]), 64'd2);
        chk("t1_opc1", 64'(out_opcode[13:7]), 64'h23);
        chk("t1_pc0", out_pc[63:0], 64'h1000);
        chk("t1_pc1", out_pc[127:64], 64'h1004);
        chk("t1_pc2", out_pc[191:128], 64'h1008);
        chk("t1_pc3", out_pc[255:192], 64'h100C);

        // Illegal lane 1 squashes lanes 2 and 3.
        send_grp(64'h2000, {32'h00000013, 32'h00208033, 32'h00000000, 32'h00500093}, 4'b1111);
        chk("t2_illegal", 64'(out_illegal), 64'b0010);
        chk("t2_lane_v", 64'(out_lane_v), 64'b0011);
        chk("t2_prd_v", 64'(out_prd_v), 64'b0001);

        // Immediate sign extension: I, U (negative), B (-4).
        send_grp(64'h3000, {32'h00000013, 32'h00000013, 32'h800000B7, 32'hFFF00093}, 4'b1111);
        chk("t3_imme_i_neg", out_imme[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t3_imme_u_neg", out_imme[127:64], 64'hFFFF_FFFF_8000_0000);
        chk("t3_prd_v", 64'(out_prd_v), 64'b0011);
        send_grp(64'h3100, {32'h00000013, 32'h00000013, 32'h00000013, 32'hFE000EE3}, 4'b1111);
        chk("t3_imme_b", out_imme[63:0], 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t3_b_prs2", 64'(out_prs2_v[0]), 64'd1);
        chk("t3_b_prd", 64'(out_prd_v[0]), 64'd0);

        // Backpressure: A fills main, B fills skid, C waits for release.
        repeat (3) @(posedge clk);
        #1;
        deliv.delete();
        out_ready = 1'b0;
        fork
            begin
                send_grp(64'h100, {4{32'h00000013}}, 4'b1111);
                send_grp(64'h200, {4{32'h00000013}}, 4'b1111);
                send_grp(64'h300, {4{32'h00000013}}, 4'b1111);
            end
            begin
                repeat (2) @(posedge clk);
                #2;
                chk("bp_in_ready_skid_full", 64'(in_ready), 64'd0);
                chk("bp_main_is_a", out_pc[63:0], 64'h100);
                repeat (2) @(posedge clk);
                #2;
                chk("bp_in_ready_held", 64'(in_ready), 64'd0);
                out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("bp_count", 64'(deliv.size()), 64'd3);
        chk("bp_first", q_at(0), 64'h100);
        chk("bp_second", q_at(1), 64'h200);
        chk("bp_third", q_at(2), 64'h300);

        // Flush with main and skid full and a new group offered.
        out_ready = 1'b0;
        deliv.delete();
        send_grp(64'h400, {4{32'h00000013}}, 4'b1111);
        send_grp(64'h500, {4{32'h00000013}}, 4'b1111);
        chk("fl_skid_full", 64'(in_ready), 64'd0);
        in_pc     = 64'h600;
        in_valid  = 1'b1;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("fl_nothing_delivered", 64'(deliv.size()), 64'd0);

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        send_grp(64'h700, {4{32'h00000013}}, 4'b1111);
        chk("ar_before", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("ar_out_valid", 64'(out_valid), 64'd0);
        chk("ar_in_ready", 64'(in_ready), 64'd1);
        chk("ar_pc0", out_pc[63:0], 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

`ifdef DECODE_STAGE_PERF_EN
        // 3 groups with 4, 2, 4 valid lanes and 5 stall cycles.
        chk("pf_reset_grp", perf_group_cnt, 64'd0);
        out_ready = 1'b0;
        send_grp(64'h800, {4{32'h00000013}}, 4'b1111);
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_grp(64'h900, {4{32'h00000013}}, 4'b0011);
        send_grp(64'hA00, {4{32'h00000013}}, 4'b1111);
        repeat (3) @(posedge clk);
        #1;
        chk("pf_group_cnt", perf_group_cnt, 64'd3);
        chk("pf_instr_cnt", perf_instr_cnt, 64'd10);
        chk("pf_stall_cnt", perf_stall_cnt, 64'd5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
